// File: rtl/frame_stage_sequencer.sv
// Frame-chain controller: launches enabled stages in order, ping-pongs the two
// frame banks between source and destination, and guards each stage with a watchdog.
module frame_stage_sequencer #(
  parameter int NUM_STAGES = 3,
  parameter int TIMEOUT    = 16777216
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       go,
  input  logic                       abort,
  input  logic [NUM_STAGES-1:0]      stage_en,
  output logic [NUM_STAGES-1:0]      stage_start,
  input  logic [NUM_STAGES-1:0]      stage_done,
  input  logic [19*NUM_STAGES-1:0]   stage_read_addr,
  input  logic [19*NUM_STAGES-1:0]   stage_write_addr,
  input  logic [36*NUM_STAGES-1:0]   stage_write_data,
  input  logic [NUM_STAGES-1:0]      stage_we,
  output logic [35:0]                stage_read_data,
  input  logic [18:0]                disp_addr,
  output logic [18:0]                mem0_addr,
  output logic [18:0]                mem1_addr,
  output logic [35:0]                mem0_wdata,
  output logic [35:0]                mem1_wdata,
  output logic                       mem0_we,
  output logic                       mem1_we,
  input  logic [35:0]                mem0_rdata,
  input  logic [35:0]                mem1_rdata,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic [1:0]                 active_stage,
  output logic                       result_bank
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SELECT = 3'd1;
  localparam logic [2:0] S_LAUNCH = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_SWAP   = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;
  localparam logic [2:0] S_ERROR  = 3'd6;

  localparam logic [24:0] WD_LAST = 25'(TIMEOUT - 1);
  localparam logic [2:0]  IDX_END = 3'(NUM_STAGES);

  logic [2:0]  state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic        src_q, src_d;
  logic        result_bank_q, result_bank_d;
  logic [24:0] wd_q, wd_d;

  // Signals of the slot addressed by idx; all zero once idx runs past the last slot.
  logic [18:0] cur_rd_addr, cur_wr_addr;
  logic [35:0] cur_wdata;
  logic        cur_we, cur_done, cur_en;

  always_comb begin
    cur_rd_addr = '0;
    cur_wr_addr = '0;
    cur_wdata   = '0;
    cur_we      = 1'b0;
    cur_done    = 1'b0;
    cur_en      = 1'b0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (idx_q == 3'(k)) begin
        cur_rd_addr = stage_read_addr[19*k +: 19];
        cur_wr_addr = stage_write_addr[19*k +: 19];
        cur_wdata   = stage_write_data[36*k +: 36];
        cur_we      = stage_we[k];
        cur_done    = stage_done[k];
        cur_en      = stage_en[k];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    src_d         = src_q;
    result_bank_d = result_bank_q;
    wd_d          = wd_q;
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_ERROR: begin
          if (go) begin
            state_d = S_SELECT;
            idx_d   = '0;
            src_d   = 1'b0;
          end
        end
        S_SELECT: begin
          if (idx_q >= IDX_END)  state_d = S_FINISH;
          else if (cur_en)       state_d = S_LAUNCH;
          else                   idx_d   = idx_q + 3'd1;
        end
        S_LAUNCH: begin
          wd_d    = '0;
          state_d = S_RUN;
        end
        S_RUN: begin
          if (cur_done)             state_d = S_SWAP;
          else if (wd_q == WD_LAST) state_d = S_ERROR;
          else                      wd_d    = wd_q + 25'd1;
        end
        S_SWAP: begin
          src_d   = ~src_q;
          idx_d   = idx_q + 3'd1;
          state_d = S_SELECT;
        end
        S_FINISH: begin
          result_bank_d = src_q;
          state_d       = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      src_q         <= 1'b0;
      result_bank_q <= 1'b0;
      wd_q          <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      src_q         <= src_d;
      result_bank_q <= result_bank_d;
      wd_q          <= wd_d;
    end
  end

  // SELECT/FINISH keep the stage routing so addresses settle early, but never write.
  logic route_on, route_we;

  always_comb begin
    route_on = (state_q == S_SELECT) || (state_q == S_LAUNCH) || (state_q == S_RUN) ||
               (state_q == S_SWAP)   || (state_q == S_FINISH);
    route_we = cur_we && ((state_q == S_LAUNCH) || (state_q == S_RUN) || (state_q == S_SWAP));
    mem0_addr  = disp_addr;
    mem1_addr  = disp_addr;
    mem0_wdata = '0;
    mem1_wdata = '0;
    mem0_we    = 1'b0;
    mem1_we    = 1'b0;
    if (route_on) begin
      if (src_q) begin
        mem1_addr  = cur_rd_addr;
        mem0_addr  = cur_wr_addr;
        mem0_wdata = cur_wdata;
        mem0_we    = route_we;
      end else begin
        mem0_addr  = cur_rd_addr;
        mem1_addr  = cur_wr_addr;
        mem1_wdata = cur_wdata;
        mem1_we    = route_we;
      end
    end
  end

  always_comb begin
    stage_start = '0;
    for (int k = 0; k < NUM_STAGES; k++)
      stage_start[k] = (state_q == S_LAUNCH) && (idx_q == 3'(k));
  end

  assign stage_read_data = src_q ? mem1_rdata : mem0_rdata;
  assign busy         = (state_q == S_SELECT) || (state_q == S_LAUNCH) || (state_q == S_RUN) ||
                        (state_q == S_SWAP)   || (state_q == S_FINISH);
  assign done         = (state_q == S_FINISH);
  assign error        = (state_q == S_ERROR);
  assign active_stage = idx_q[1:0];
  assign result_bank  = result_bank_q;

endmodule

// File: tb/tb_frame_stage_sequencer.sv
// Bench for frame_stage_sequencer: a schedule model derived from cycle-count rules,
// checked every cycle, plus literal timing expectations per scenario.
module tb_frame_stage_sequencer;
  localparam int NS   = 3;
  localparam int MAXC = 64;
  localparam logic [35:0] RD0 = 36'hA_0000_0A0A;
  localparam logic [35:0] RD1 = 36'hB_1111_1B1B;

  logic clk = 1'b0, reset = 1'b1, go = 1'b0, abort = 1'b0;
  logic [NS-1:0] stage_en = '0, stage_done = '0, stage_we = '1, stage_start;
  logic [18:0] rd_a [NS], wr_a [NS];
  logic [35:0] wr_d [NS];
  logic [19*NS-1:0] s_rd, s_wr;
  logic [36*NS-1:0] s_wd;
  logic [35:0] stage_read_data, mem0_wdata, mem1_wdata;
  logic [18:0] disp_addr = 19'h5A5A5, mem0_addr, mem1_addr;
  logic mem0_we, mem1_we, busy, done, error, result_bank;
  logic [1:0] active_stage;

  assign s_rd = {rd_a[2], rd_a[1], rd_a[0]};
  assign s_wr = {wr_a[2], wr_a[1], wr_a[0]};
  assign s_wd = {wr_d[2], wr_d[1], wr_d[0]};

  frame_stage_sequencer #(.NUM_STAGES(NS), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .go(go), .abort(abort), .stage_en(stage_en),
    .stage_start(stage_start), .stage_done(stage_done), .stage_read_addr(s_rd),
    .stage_write_addr(s_wr), .stage_write_data(s_wd), .stage_we(stage_we),
    .stage_read_data(stage_read_data), .disp_addr(disp_addr),
    .mem0_addr(mem0_addr), .mem1_addr(mem1_addr), .mem0_wdata(mem0_wdata),
    .mem1_wdata(mem1_wdata), .mem0_we(mem0_we), .mem1_we(mem1_we),
    .mem0_rdata(RD0), .mem1_rdata(RD1), .busy(busy), .done(done), .error(error),
    .active_stage(active_stage), .result_bank(result_bank));

  always #5 clk = ~clk;

  int nchk = 0, nfail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Expected per-cycle picture of a scenario (cycle 0 = the cycle go is high).
  // mode: 0 display routing, 1 stage running, 2 select/finish (no writes), 3 unchecked routing
  bit          e_busy [MAXC], e_done [MAXC], e_err [MAXC], e_rb [MAXC], e_src [MAXC];
  logic [2:0]  e_start [MAXC];
  int          e_mode [MAXC], e_stg [MAXC];
  bit          m_rb = 0, m_src = 0, m_err = 0;
  bit          chk_on = 0;
  int          t = 0;

  task automatic mark(input int c, input bit b, input int md, input int st, input bit sr);
    if (c >= 0 && c < MAXC) begin
      e_busy[c] = b; e_mode[c] = md; e_stg[c] = st; e_src[c] = sr;
    end
  endtask

  task automatic build_exp(input logic [2:0] en, input int hang, input int ab, input int len);
    int c, s;
    bit dead, src, held;
    for (int i = 0; i < MAXC; i++) begin
      mark(i, 0, 0, 0, m_src);
      e_done[i] = 0; e_err[i] = 0; e_start[i] = '0; e_rb[i] = m_rb;
    end
    e_err[0] = m_err;
    c = 1; src = 0; dead = 0;
    for (int k = 0; k < NS && !dead; k++) begin
      if (en[k]) begin
        s = c + 1;
        mark(c, 1, 2, k, src);
        mark(s, 1, 3, k, src);
        if (s < MAXC) e_start[s][k] = 1'b1;
        if (k == hang) begin
          for (int i = s + 1; i <= s + 16; i++) mark(i, 1, 1, k, src);
          for (int i = s + 17; i < MAXC; i++) begin mark(i, 0, 0, 0, src); e_err[i] = 1; end
          dead = 1;
        end else begin
          for (int i = s + 1; i <= s + 11; i++) mark(i, 1, 1, k, src);
          mark(s + 12, 1, 3, k, src);
          src = ~src;
          c = s + 13;
        end
      end else begin
        mark(c, 1, 2, k, src);
        c++;
      end
    end
    if (!dead) begin
      mark(c, 1, 2, 0, src);
      mark(c + 1, 1, 2, 0, src);
      if (c + 1 < MAXC) e_done[c + 1] = 1;
      for (int i = c + 2; i < MAXC; i++) begin mark(i, 0, 0, 0, src); e_rb[i] = src; end
    end
    if (ab >= 0) begin
      held = e_src[ab];
      for (int i = ab + 1; i < MAXC; i++) begin
        mark(i, 0, 0, 0, held);
        e_done[i] = 0; e_start[i] = '0; e_err[i] = 0; e_rb[i] = m_rb;
      end
    end
    m_rb = e_rb[len-1]; m_src = e_src[len-1]; m_err = e_err[len-1];
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("busy", busy, e_busy[t]);
      chk("done", done, e_done[t]);
      chk("error", error, e_err[t]);
      chk("stage_start", stage_start, e_start[t]);
      chk("result_bank", result_bank, e_rb[t]);
      chk("stage_read_data", stage_read_data, e_src[t] ? RD1 : RD0);
      case (e_mode[t])
        0: begin
          chk("idle mem0_addr", mem0_addr, disp_addr);
          chk("idle mem1_addr", mem1_addr, disp_addr);
          chk("idle mem0_we", mem0_we, 0);
          chk("idle mem1_we", mem1_we, 0);
          chk("idle wdata", {mem0_wdata, mem1_wdata}, 0);
        end
        1: begin
          chk("run active_stage", active_stage, e_stg[t]);
          chk("run src addr", e_src[t] ? mem1_addr : mem0_addr, rd_a[e_stg[t]]);
          chk("run src we", e_src[t] ? mem1_we : mem0_we, 0);
          chk("run dst addr", e_src[t] ? mem0_addr : mem1_addr, wr_a[e_stg[t]]);
          chk("run dst wdata", e_src[t] ? mem0_wdata : mem1_wdata, wr_d[e_stg[t]]);
          chk("run dst we", e_src[t] ? mem0_we : mem1_we, 1);
        end
        2: begin
          chk("sel mem0_we", mem0_we, 0);
          chk("sel mem1_we", mem1_we, 0);
        end
        default: ;
      endcase
    end
  end

  int st_t [NS];
  int done_t, err_t;
  logic [18:0] r0a, r1a;
  logic r0w, r1w;

  task automatic run_scn(input logic [2:0] en, input int hang, input int ab, input int len);
    int due [NS];
    build_exp(en, hang, ab, len);
    stage_en = en;
    for (int k = 0; k < NS; k++) begin due[k] = -1; st_t[k] = -1; end
    done_t = -1; err_t = -1;
    for (int i = 0; i < len; i++) begin
      @(posedge clk); #1;
      t = i; chk_on = 1;
      go = (i == 0);
      abort = (i == ab);
      for (int k = 0; k < NS; k++) stage_done[k] = (due[k] == i);
      for (int k = 0; k < NS; k++)
        if (stage_start[k]) begin
          if (st_t[k] < 0) st_t[k] = i;
          if (k != hang) due[k] = i + 11;
        end
      if (done && done_t < 0) done_t = i;
      if (error && err_t < 0) err_t = i;
      if (i == 8) begin r0a = mem0_addr; r0w = mem0_we; r1a = mem1_addr; r1w = mem1_we; end
    end
    @(posedge clk); #1;
    chk_on = 0; go = 0; abort = 0; stage_done = '0;
  endtask

  initial begin
    rd_a[0] = 19'h00011; wr_a[0] = 19'h00022; wr_d[0] = 36'h0_1234_5678;
    rd_a[1] = 19'h00123; wr_a[1] = 19'h00456; wr_d[1] = 36'h9_8765_4321;
    rd_a[2] = 19'h00777; wr_a[2] = 19'h00888; wr_d[2] = 36'hC_AFE0_0BAD;
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst error", error, 0);
    chk("rst start", stage_start, 0);
    chk("rst active_stage", active_stage, 0);
    chk("rst result_bank", result_bank, 0);
    chk("rst we", {mem0_we, mem1_we}, 0);
    chk("rst mem0_addr", mem0_addr, disp_addr);
    chk("rst mem1_addr", mem1_addr, disp_addr);
    reset = 1'b0;

    // all three stages
    run_scn(3'b111, -1, -1, 48);
    chk("all st0", st_t[0], 2);
    chk("all st1", st_t[1], 16);
    chk("all st2", st_t[2], 30);
    chk("all done", done_t, 44);
    chk("all result_bank", result_bank, 1);

    // routing, stage1 only
    disp_addr = 19'h2B2B2;
    run_scn(3'b010, -1, -1, 22);
    chk("route st1", st_t[1], 3);
    chk("route mem0_addr", r0a, 19'h00123);
    chk("route mem0_we", r0w, 0);
    chk("route mem1_addr", r1a, 19'h00456);
    chk("route mem1_we", r1w, 1);
    chk("route result_bank", result_bank, 1);

    // nothing enabled
    run_scn(3'b000, -1, -1, 9);
    chk("none done", done_t, 5);
    chk("none starts", {st_t[2] < 0, st_t[1] < 0, st_t[0] < 0}, 3'b111);
    chk("none result_bank", result_bank, 0);

    // watchdog on a hung stage0
    run_scn(3'b001, 0, -1, 25);
    chk("wd error cycle", err_t, 19);
    chk("wd error", error, 1);
    chk("wd busy", busy, 0);
    chk("wd we", {mem0_we, mem1_we}, 0);

    // restart out of ERROR
    run_scn(3'b011, -1, -1, 35);
    chk("restart done", done_t, 31);
    chk("restart error", error, 0);
    chk("restart result_bank", result_bank, 0);

    // abort mid-RUN of stage1
    run_scn(3'b111, -1, 20, 26);
    chk("abort done", done_t, -1);
    chk("abort busy", busy, 0);
    chk("abort result_bank", result_bank, 0);
    chk("abort mem0_addr", mem0_addr, disp_addr);

    // async reset between edges while running
    run_scn(3'b111, -1, -1, 6);
    #2 reset = 1'b1;
    #1;
    chk("arst busy", busy, 0);
    chk("arst we", {mem0_we, mem1_we}, 0);
    chk("arst mem0_addr", mem0_addr, disp_addr);
    chk("arst mem1_addr", mem1_addr, disp_addr);
    chk("arst active_stage", active_stage, 0);
    chk("arst result_bank", result_bank, 0);
    @(posedge clk); #1 reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule
